d_counter_monitor: RTL
======================

// Module: d_counter_monitor
// PURPOSE
//  Passive observer on the counter's rstn/dir/out interface, at the receiving end of that interface.
//  Keeps a cycle-accurate reference model of the up/down counter and compares it to the DUT's `out`.
//  Flags mismatches, counts errors and reports wrap-around events.
//  Sits beside d_counter in the bench or in the self-checking SoC test harness; it never drives the DUT.
// PARAMETERS
//  WIDTH      4  counter width; must match the observed d_counter
//  ERR_CNT_W  8  width of the saturating error counter
// PORTS
//  clk        in   1          same clock as the observed counter
//  rstn       in   1          monitor reset; asynchronous, active-low
//  mon_rstn   in   1          observed DUT reset (the DUT's synchronous active-low clear)
//  mon_dir    in   1          observed direction: 1 = up, 0 = down
//  mon_out    in   WIDTH      observed DUT counter output
//  chk_en     in   1          1 = comparisons enabled
//  exp_out    out  WIDTH      model's expected value of mon_out
//  mismatch   out  1          one-cycle pulse on a compare failure
//  err_cnt    out  ERR_CNT_W  saturating mismatch count
//  wrap_up    out  1          one-cycle pulse: model wraps max -> 0
//  wrap_dn    out  1          one-cycle pulse: model wraps 0 -> max
//  state      out  2          00 UNSYNC, 01 TRACK, 10 FAIL
// BEHAVIOUR
//  Reset
//   - rstn low, at any time including mid-run: state = UNSYNC.
//   - exp_out, err_cnt, mismatch, wrap_up and wrap_dn all go to 0 immediately.
//  Sampling
//   - All inputs are sampled at posedge clk, using the pre-edge values the DUT also sees.
//  Model update (at each posedge, in every state)
//   - exp_out <= !mon_rstn ? 0 : (mon_dir ? exp_out+1 : exp_out-1).
//   - Arithmetic is modulo 2^WIDTH.
//  FSM
//   - UNSYNC -> TRACK on the first posedge with mon_rstn == 0. No compares occur in UNSYNC.
//   - TRACK -> FAIL on the posedge where err_cnt would reach all-ones.
//   - FAIL is left only via rstn. In FAIL the model keeps running; mismatch stays 0; err_cnt holds.
//  Compare (TRACK only)
//   - Compare happens when chk_en == 1 and mon_rstn == 1, at the posedge that samples mon_out.
//   - Compare condition: mon_out != exp_out (exp_out's pre-edge value).
//   - Result is registered: mismatch is high for the cycle after that edge (latency 1).
//   - err_cnt increments on the same edge as mismatch and saturates at 2^ERR_CNT_W-1.
//   - A posedge with mon_rstn == 0 is never compared. The edge after the clear compares against 0.
//   - chk_en == 0: no compare and no error increment; the model and FSM continue to update.
//  Wrap flags
//   - Registered, latency 1, and valid in TRACK only.
//   - wrap_up when mon_rstn=1, mon_dir=1, exp_out=2^WIDTH-1.
//   - wrap_dn when mon_rstn=1, mon_dir=0, exp_out=0.
//   - A clear takes priority over a wrap: no wrap pulse on clear edges.
//  Simultaneous events
//   - A mismatch and a wrap on the same edge produce both pulses.
//   - Saturation and mismatch on the same edge: mismatch pulses, err_cnt = max, state = FAIL.
// CONFIGURATION
//  D_COUNTER_MON_RESYNC_EN
//   - Defined: on a mismatch edge the model reloads from the observed value.
//     exp_out <= mon_dir ? mon_out+1 : mon_out-1, so one DUT glitch gives exactly one error.
//   - Undefined: the model continues from its own value, so one glitch can give repeated errors.
// TESTING
//  T1 Reset:
//     rstn low mid-count -> all outputs 0 immediately; state=00; no compares until mon_rstn pulses low.
//  T2 Up count:
//     clear 2 cycles, then dir=1 for 16 cycles -> exp tracks 0..F,0.
//     wrap_up pulses once, one cycle after the F->0 edge; err_cnt=0.
//  T3 Down count:
//     clear, then dir=0 -> exp F,E,...; wrap_dn pulses once after the first edge; mismatch never high.
//  T4 Injected error:
//     force mon_out=5 for one cycle when exp=3 -> mismatch pulses the next cycle; err_cnt=1.
//     With RESYNC_EN: err_cnt stays 1.
//     Without RESYNC_EN: with the model off by 2 relative to the DUT, each later compare mismatches.
//  T5 Saturation:
//     ERR_CNT_W=2, repeated mismatches -> err_cnt 1,2,3; state=10 after the third.
//     Further mismatches give no pulse.
//  T6 Gating:
//     chk_en=0 with a corrupted mon_out for 4 cycles -> no mismatch, err_cnt unchanged.
//     Re-enable with a correct mon_out -> no error.

Source files
------------

// File: rtl/d_counter_monitor_if.sv
// rtl/d_counter_monitor_if.sv - observed rstn/dir/out lines of a d_counter
interface d_counter_monitor_if #(
  parameter int WIDTH = 4
);
  logic             mon_rstn;
  logic             mon_dir;
  logic [WIDTH-1:0] mon_out;

  modport master (output mon_rstn, output mon_dir, output mon_out);
  modport slave  (input  mon_rstn, input  mon_dir, input  mon_out);
endinterface

// File: rtl/d_counter_monitor.sv
// rtl/d_counter_monitor.sv - passive reference-model checker for an up/down counter
// Optional model reload on mismatch: D_COUNTER_MON_RESYNC_EN
module d_counter_monitor #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  d_counter_monitor_if.slave   mon,
  input  logic                 chk_en,
  output logic [WIDTH-1:0]     exp_out,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 wrap_up,
  output logic                 wrap_dn,
  output logic [1:0]           state
);
  typedef enum logic [1:0] {
    UNSYNC = 2'b00,
    TRACK  = 2'b01,
    FAIL   = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0]     ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0]     MAX      = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_LAST = ERR_MAX - ERR_ONE;

  state_t           state_q;
  logic [WIDTH-1:0] model_next;
  logic             cmp_fail;
  logic             tracking;

  assign state    = state_q;
  assign tracking = (state_q == TRACK);
  // The clear edge itself is never compared; the following edge compares against 0.
  assign cmp_fail = tracking && mon.mon_rstn && chk_en && (mon.mon_out != exp_out);

  always_comb begin
    model_next = '0;
    if (mon.mon_rstn) begin
      model_next = mon.mon_dir ? exp_out + ONE : exp_out - ONE;
    end
`ifdef D_COUNTER_MON_RESYNC_EN
    // Reload from the DUT so a single glitch is reported exactly once.
    if (cmp_fail) begin
      model_next = mon.mon_dir ? mon.mon_out + ONE : mon.mon_out - ONE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= UNSYNC;
      exp_out  <= '0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
      wrap_up  <= 1'b0;
      wrap_dn  <= 1'b0;
    end else begin
      exp_out  <= model_next;
      mismatch <= cmp_fail;
      wrap_up  <= tracking && mon.mon_rstn &&  mon.mon_dir && (exp_out == MAX);
      wrap_dn  <= tracking && mon.mon_rstn && !mon.mon_dir && (exp_out == '0);
      case (state_q)
        UNSYNC: begin
          if (!mon.mon_rstn) begin
            state_q <= TRACK;
          end
        end
        TRACK: begin
          if (cmp_fail && err_cnt != ERR_MAX) begin
            err_cnt <= err_cnt + ERR_ONE;
            if (err_cnt == ERR_LAST) begin
              state_q <= FAIL;
            end
          end
        end
        FAIL:    state_q <= FAIL;
        default: state_q <= UNSYNC;
      endcase
    end
  end
endmodule
